// File: rtl/dual_port_byte_mem.sv
// Byte-addressable little-endian memory: PM read port plus DM read/write port; MEM_INIT_FILL_EN adds a post-reset fill engine.
// Latency: read data and valid appear RD_LAT clocks after the sampling edge. Writes commit on the sampling edge.
// Backpressure: none. Requests are accepted every cycle, except while busy, when they are dropped.
module dual_port_byte_mem #(
    parameter int          AW        = 16,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] FILL_WORD = 32'h00000013
) (
    input  logic          clk,
    input  logic          r,
    output logic          busy,
    input  logic          pm_re,
    input  logic [AW-1:0] pm_addr,
    output logic [31:0]   pm_rdata,
    output logic          pm_rvalid,
    input  logic          dm_re,
    input  logic [AW-1:0] dm_raddr,
    output logic [31:0]   dm_rdata,
    output logic          dm_rvalid,
    input  logic [1:0]    dm_we,
    input  logic [AW-1:0] dm_waddr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_misal
);

    localparam int DEPTH = 2 ** AW;

    if (RD_LAT < 1 || RD_LAT > 4 || $bits(FILL_WORD) != 32) begin : g_bad_cfg
        $error("dual_port_byte_mem: RD_LAT must be in 1..4");
    end

    logic [7:0]    r_mem [DEPTH];

    logic [AW-1:0] w_pa [4];
    logic [AW-1:0] w_ra [4];
    logic [AW-1:0] w_wa [4];
    logic [31:0]   w_rd [2];
    logic          w_acc [2];
    logic [3:0]    w_wbe;
    logic          w_go_wr;
    logic          w_misal;

    // Byte offsets wrap naturally in AW bits
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_pa[k] = pm_addr  + AW'(k);
            w_ra[k] = dm_raddr + AW'(k);
            w_wa[k] = dm_waddr + AW'(k);
        end
        w_rd[0] = {r_mem[w_pa[3]], r_mem[w_pa[2]], r_mem[w_pa[1]], r_mem[w_pa[0]]};
        w_rd[1] = {r_mem[w_ra[3]], r_mem[w_ra[2]], r_mem[w_ra[1]], r_mem[w_ra[0]]};
    end

    always_comb begin
        case (dm_we)
            2'd1:    w_wbe = 4'b0001;
            2'd2:    w_wbe = 4'b0011;
            2'd3:    w_wbe = 4'b1111;
            default: w_wbe = 4'b0000;
        endcase
    end

    assign w_acc[0] = pm_re && !busy;
    assign w_acc[1] = dm_re && !busy;
    assign w_go_wr  = (dm_we != 2'd0) && !busy;
    assign w_misal  = !busy && ((dm_re && (dm_raddr[1:0] != 2'b00)) ||
                                ((dm_we == 2'd2) && dm_waddr[0]) ||
                                ((dm_we == 2'd3) && (dm_waddr[1:0] != 2'b00)));

`ifdef MEM_INIT_FILL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [AW-3:0] r_cnt;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= r_state;
            endcase
        end
    end

    assign busy = (r_state == S_FILL);
`else
    assign busy = 1'b0;
`endif

    // Array is never reset; fill and DM writes are mutually exclusive through busy
    always_ff @(posedge clk) begin
`ifdef MEM_INIT_FILL_EN
        if (r_state == S_FILL) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[{r_cnt, 2'(k)}] <= FILL_WORD[8*k +: 8];
            end
        end else
`endif
        if (w_go_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wbe[k]) r_mem[w_wa[k]] <= dm_wdata[8*k +: 8];
            end
        end
    end

    // Data is captured at the sampling edge (read-first), then delayed to the output register
    logic [31:0] r_pd   [2][RD_LAT];
    logic        r_pv   [2][RD_LAT];
    logic [31:0] r_odat [2];
    logic        r_ovld [2];
    logic        r_misal;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    r_pd[p][s] <= '0;
                    r_pv[p][s] <= 1'b0;
                end
                r_odat[p] <= '0;
                r_ovld[p] <= 1'b0;
            end
            r_misal <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_pv[p][0] <= w_acc[p];
                if (w_acc[p]) r_pd[p][0] <= w_rd[p];
                for (int s = 1; s < RD_LAT; s++) begin
                    r_pv[p][s] <= r_pv[p][s-1];
                    r_pd[p][s] <= r_pd[p][s-1];
                end
                r_ovld[p] <= r_pv[p][RD_LAT-1];
                if (r_pv[p][RD_LAT-1]) r_odat[p] <= r_pd[p][RD_LAT-1];
            end
            r_misal <= w_misal;
        end
    end

    assign pm_rdata  = r_odat[0];
    assign pm_rvalid = r_ovld[0];
    assign dm_rdata  = r_odat[1];
    assign dm_rvalid = r_ovld[1];
    assign dm_misal  = r_misal;

endmodule

// File: tb/tb_dual_port_byte_mem.sv
// Bench for dual_port_byte_mem: RD_LAT=1 and RD_LAT=3 instances share stimulus; an AW=10 instance covers the fill engine.
module tb_dual_port_byte_mem;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        r;
    logic        pm_re, dm_re;
    logic [15:0] pm_addr, dm_raddr, dm_waddr;
    logic [1:0]  dm_we;
    logic [31:0] dm_wdata;
    logic        pm_re10;
    logic [9:0]  pm_addr10;

    logic        busy1, pm_rvalid1, dm_rvalid1, dm_misal1;
    logic [31:0] pm_rdata1, dm_rdata1;
    logic        busy3, pm_rvalid3, dm_rvalid3, dm_misal3;
    logic [31:0] pm_rdata3, dm_rdata3;

    logic        vld [5];
    logic [31:0] dat [5];
    logic [31:0] last [5];
    string       nm [5] = '{"u1.pm", "u1.dm", "u3.pm", "u3.dm", "u10.pm"};

    exp_t        q [5][$];
    int          mq [$];
    logic [7:0]  m [65536];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_byte_mem #(.AW(16), .RD_LAT(1)) u1 (
        .clk(clk), .r(r), .busy(busy1),
        .pm_re(pm_re), .pm_addr(pm_addr), .pm_rdata(pm_rdata1), .pm_rvalid(pm_rvalid1),
        .dm_re(dm_re), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata1), .dm_rvalid(dm_rvalid1),
        .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata), .dm_misal(dm_misal1)
    );

    dual_port_byte_mem #(.AW(16), .RD_LAT(3)) u3 (
        .clk(clk), .r(r), .busy(busy3),
        .pm_re(pm_re), .pm_addr(pm_addr), .pm_rdata(pm_rdata3), .pm_rvalid(pm_rvalid3),
        .dm_re(dm_re), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata3), .dm_rvalid(dm_rvalid3),
        .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata), .dm_misal(dm_misal3)
    );

    assign vld[0] = pm_rvalid1;  assign dat[0] = pm_rdata1;
    assign vld[1] = dm_rvalid1;  assign dat[1] = dm_rdata1;
    assign vld[2] = pm_rvalid3;  assign dat[2] = pm_rdata3;
    assign vld[3] = dm_rvalid3;  assign dat[3] = dm_rdata3;

`ifdef MEM_INIT_FILL_EN
    logic        busy10, pm_rvalid10, dm_rvalid10, dm_misal10;
    logic [31:0] pm_rdata10, dm_rdata10;

    dual_port_byte_mem #(.AW(10), .RD_LAT(1)) u10 (
        .clk(clk), .r(r), .busy(busy10),
        .pm_re(pm_re10), .pm_addr(pm_addr10), .pm_rdata(pm_rdata10), .pm_rvalid(pm_rvalid10),
        .dm_re(1'b0), .dm_raddr(10'h000), .dm_rdata(dm_rdata10), .dm_rvalid(dm_rvalid10),
        .dm_we(2'd0), .dm_waddr(10'h000), .dm_wdata(32'h0), .dm_misal(dm_misal10)
    );

    assign vld[4] = pm_rvalid10; assign dat[4] = pm_rdata10;
`else
    assign vld[4] = 1'b0;        assign dat[4] = 32'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [15:0] a);
        return {m[a + 16'd3], m[a + 16'd2], m[a + 16'd1], m[a]};
    endfunction

    task automatic push(input int i, input logic [31:0] d, input int c);
        exp_t e;
        e.dat = d;
        e.cyc = c;
        q[i].push_back(e);
    endtask

    // Record expectations for the inputs now on the bus, then let the edge sample them
    task automatic tick();
        int sn;
        int nb;
        sn = cyc + 1;
        if (pm_re) begin
            push(0, rd(pm_addr), sn + 1);
            push(2, rd(pm_addr), sn + 3);
        end
        if (dm_re) begin
            push(1, rd(dm_raddr), sn + 1);
            push(3, rd(dm_raddr), sn + 3);
        end
        if ((dm_re && dm_raddr[1:0] != 2'b00) || (dm_we == 2'd2 && dm_waddr[0]) ||
            (dm_we == 2'd3 && dm_waddr[1:0] != 2'b00))
            mq.push_back(sn);
        nb = (dm_we == 2'd3) ? 4 : int'(dm_we);
        for (int k = 0; k < nb; k++) m[dm_waddr + 16'(k)] = dm_wdata[8*k +: 8];
        @(posedge clk);
        #1;
        pm_re = 1'b0;
        dm_re = 1'b0;
        dm_we = 2'd0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic em;
        for (int i = 0; i < 5; i++) begin
            if (r) begin
                last[i] = 32'h0;
            end else begin
                if (q[i].size() > 0) begin
                    tests++;
                    assert (q[i][0].cyc >= cyc) else begin
                        fails++;
                        $error("FAIL %s missing rvalid: got none at cycle %0d expected %h", nm[i], cyc, q[i][0].dat);
                        void'(q[i].pop_front());
                    end
                end
                if (vld[i]) begin
                    tests++;
                    assert (q[i].size() != 0) else begin
                        fails++;
                        $error("FAIL %s spurious rvalid: got %h expected no valid", nm[i], dat[i]);
                    end
                    if (q[i].size() != 0) begin
                        e = q[i].pop_front();
                        chk({nm[i], " data"}, dat[i], e.dat);
                        chk({nm[i], " cycle"}, 32'(cyc), 32'(e.cyc));
                    end
                    last[i] = dat[i];
                end else begin
                    chk({nm[i], " hold"}, dat[i], last[i]);
                end
            end
        end
        if (!r) begin
            em = (mq.size() > 0 && mq[0] == cyc);
            if (em) void'(mq.pop_front());
            if (dm_misal1 || em) chk("u1 misal", {31'h0, dm_misal1}, {31'h0, em});
            if (dm_misal3 || em) chk("u3 misal", {31'h0, dm_misal3}, {31'h0, em});
        end
    end

    initial begin
        r = 1'b1;
        pm_re = 1'b0; dm_re = 1'b0; dm_we = 2'd0;
        pm_addr = '0; dm_raddr = '0; dm_waddr = '0; dm_wdata = '0;
        pm_re10 = 1'b0; pm_addr10 = '0;
        for (int i = 0; i < 65536; i++) begin
`ifdef MEM_INIT_FILL_EN
            m[i] = (i % 4 == 0) ? 8'h13 : 8'h00;
`else
            m[i] = 8'h00;
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst pm_rdata1", pm_rdata1, 32'h0);
        chk("rst dm_rdata1", dm_rdata1, 32'h0);
        chk("rst pm_rvalid1", {31'h0, pm_rvalid1}, 32'h0);
        chk("rst dm_rvalid1", {31'h0, dm_rvalid1}, 32'h0);
        chk("rst dm_misal1", {31'h0, dm_misal1}, 32'h0);
        chk("rst dm_rdata3", dm_rdata3, 32'h0);
`ifdef MEM_INIT_FILL_EN
        chk("rst busy1", {31'h0, busy1}, 32'h1);
`else
        chk("rst busy1", {31'h0, busy1}, 32'h0);
`endif
        r = 1'b0;

`ifdef MEM_INIT_FILL_EN
        chk("fill busy10 at release", {31'h0, busy10}, 32'h1);
        repeat (50) @(posedge clk);
        #1;
        pm_re10 = 1'b1;
        pm_addr10 = 10'h000;
        @(posedge clk);
        #1;
        pm_re10 = 1'b0;
        chk("fill busy10 mid", {31'h0, busy10}, 32'h1);
        repeat (48) @(posedge clk);
        #1;
        r = 1'b1;
        #1;
        chk("fill busy10 in reset", {31'h0, busy10}, 32'h1);
        @(posedge clk);
        #1;
        r = 1'b0;
        n = 0;
        while (busy10 === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fill length", 32'(n), 32'd256);
        pm_re10 = 1'b1;
        pm_addr10 = 10'h3FC; push(4, 32'h00000013, cyc + 2);
        @(posedge clk); #1;
        pm_addr10 = 10'h000; push(4, 32'h00000013, cyc + 2);
        @(posedge clk); #1;
        pm_addr10 = 10'h200; push(4, 32'h00000013, cyc + 2);
        @(posedge clk); #1;
        pm_re10 = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u1 busy drops", {31'h0, busy1}, 32'h0);
`endif

        dm_we = 2'd3; dm_waddr = 16'h0200; dm_wdata = 32'h00000000; tick();
        dm_we = 2'd3; dm_waddr = 16'h0000; dm_wdata = 32'h0A0B0C0D; tick();
        dm_we = 2'd3; dm_waddr = 16'h0004; dm_wdata = 32'h1A1B1C1D; tick();
        dm_we = 2'd3; dm_waddr = 16'h0008; dm_wdata = 32'h2A2B2C2D; tick();
        dm_we = 2'd3; dm_waddr = 16'h0100; dm_wdata = 32'hDEADBEEF; tick();
        dm_re = 1'b1; dm_raddr = 16'h0100; tick();
        pm_re = 1'b1; pm_addr = 16'h0000; tick();
        pm_re = 1'b1; pm_addr = 16'h0004; tick();
        pm_re = 1'b1; pm_addr = 16'h0008; tick();
        dm_we = 2'd1; dm_waddr = 16'h0101; dm_wdata = 32'h00000055; tick();
        dm_we = 2'd2; dm_waddr = 16'h0103; dm_wdata = 32'h00001234; tick();
        dm_re = 1'b1; dm_raddr = 16'h0100; tick();
        dm_we = 2'd3; dm_waddr = 16'hFFFE; dm_wdata = 32'h11223344; tick();
        pm_re = 1'b1; pm_addr = 16'hFFFE; dm_re = 1'b1; dm_raddr = 16'hFFFF; tick();
        dm_we = 2'd3; dm_waddr = 16'h0200; dm_wdata = 32'hA5A5A5A5;
        dm_re = 1'b1; dm_raddr = 16'h0200; pm_re = 1'b1; pm_addr = 16'h0200; tick();
        dm_re = 1'b1; dm_raddr = 16'h0200; tick();
        dm_we = 2'd3; dm_waddr = 16'h0302; dm_wdata = 32'hCAFEF00D; tick();
        dm_we = 2'd2; dm_waddr = 16'h0300; dm_wdata = 32'h00007788; tick();
        dm_re = 1'b1; dm_raddr = 16'h0301; pm_re = 1'b1; pm_addr = 16'h0300; tick();
        dm_we = 2'd1; dm_waddr = 16'h0303; dm_wdata = 32'hFFFFFF99; tick();
        dm_re = 1'b1; dm_raddr = 16'h0300; tick();
        repeat (6) tick();

        // In-flight reads must be discarded by an asynchronous reset
        pm_re = 1'b1; pm_addr = 16'h0000; dm_re = 1'b1; dm_raddr = 16'h0100; tick();
        r = 1'b1;
        for (int i = 0; i < 5; i++) q[i].delete();
        mq.delete();
        #1;
        chk("flush pm_rvalid3", {31'h0, pm_rvalid3}, 32'h0);
        chk("flush pm_rdata3", pm_rdata3, 32'h0);
        chk("flush dm_rdata1", dm_rdata1, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        r = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) chk({nm[i], " drained"}, 32'(q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
